// File: rtl/adc0809_responder.sv
// Emulates the converter side of an ADC0809 START/ALE/EOC/OE handshake.
// Channel codes come from the ain vector instead of an analog front end.
module adc0809_responder #(
   parameter int NCH         = 8,
   parameter int EOC_DELAY   = 8,
   parameter int CONV_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ale,
   input  logic [2:0]       addr,
   input  logic             oe,
   input  logic [8*NCH-1:0] ain,
   output logic             eoc,
   output logic [7:0]       dout,
   output logic             dout_en,
   output logic             busy
);

   localparam int MAXC = (EOC_DELAY > CONV_CYCLES) ? EOC_DELAY : CONV_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] EOC_DLY_C = CW'(EOC_DELAY);
   localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_SAMPLE,
      S_CONV,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic          start_q, start_d, start_prev_q, start_prev_d;
   logic          ale_q, ale_d, ale_prev_q, ale_prev_d;
   logic          oe_q, oe_d;
   logic [2:0]    addr_q, addr_d;
   logic [2:0]    ch_q, ch_d;
   logic [CW-1:0] dly_q, dly_d;
   logic [CW-1:0] conv_q, conv_d;
   logic [7:0]    sample_q, sample_d;
   logic [7:0]    latch_q, latch_d;
   logic          eoc_q, eoc_d;
   logic          busy_q, busy_d;
   logic [7:0]    dout_q, dout_d;
   logic          dout_en_q, dout_en_d;

   logic          start_rise, start_fall, ale_rise, restart;
   logic [CW-1:0] dly_inc, conv_inc;
   logic [7:0]    chan_code [8];

   // Unimplemented channel slots read as zero so out-of-range addresses convert to 00.
   for (genvar gi = 0; gi < 8; gi++) begin : g_chan
      if (gi < NCH) begin : g_live
         assign chan_code[gi] = ain[8*gi +: 8];
      end else begin : g_tie
         assign chan_code[gi] = 8'h00;
      end
   end

   always_comb begin
      start_d      = start;
      start_prev_d = start_q;
      ale_d        = ale;
      ale_prev_d   = ale_q;
      oe_d         = oe;
      addr_d       = addr;
      state_d      = state_q;
      ch_d         = ch_q;
      dly_d        = dly_q;
      conv_d       = conv_q;
      sample_d     = sample_q;
      latch_d      = latch_q;
      eoc_d        = eoc_q;
      busy_d       = busy_q;

      start_rise = start_q & ~start_prev_q;
      start_fall = ~start_q & start_prev_q;
      ale_rise   = ale_q & ~ale_prev_q;
      dly_inc    = (dly_q == CNT_MAX) ? dly_q : dly_q + CW'(1);
      conv_inc   = (conv_q == CNT_MAX) ? conv_q : conv_q + CW'(1);

      if (ale_rise) begin
         ch_d = addr_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               state_d = S_ARM;
               dly_d   = CW'(1);
               busy_d  = 1'b1;
            end
         end
         S_ARM: begin
            dly_d = dly_inc;
            if (start_fall) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            dly_d    = dly_inc;
            sample_d = chan_code[ch_q];
            conv_d   = '0;
            state_d  = S_CONV;
         end
         S_CONV: begin
            dly_d  = dly_inc;
            conv_d = conv_inc;
            if (conv_q == CONV_LAST) begin
               state_d = S_DONE;
               latch_d = sample_q;
               eoc_d   = 1'b1;
               busy_d  = 1'b0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            // A START arriving on the completion cycle is honoured rather than dropped.
            if (start_rise) begin
               state_d = S_ARM;
               dly_d   = CW'(1);
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            eoc_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase

      restart = start_rise && (state_q inside {S_ARM, S_SAMPLE, S_CONV});
      if (restart) begin
         state_d  = S_ARM;
         dly_d    = CW'(1);
         conv_d   = conv_q;
         sample_d = sample_q;
         latch_d  = latch_q;
         eoc_d    = eoc_q;
         busy_d   = 1'b1;
      end

      // EOC only ever falls during an active conversion, and never before the delay.
      if ((state_d inside {S_ARM, S_SAMPLE, S_CONV}) && (dly_d >= EOC_DLY_C)) begin
         eoc_d = 1'b0;
      end

      dout_en_d = oe_q;
      dout_d    = oe_q ? latch_q : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         start_q      <= 1'b0;
         start_prev_q <= 1'b0;
         ale_q        <= 1'b0;
         ale_prev_q   <= 1'b0;
         oe_q         <= 1'b0;
         addr_q       <= 3'd0;
         ch_q         <= 3'd0;
         dly_q        <= '0;
         conv_q       <= '0;
         sample_q     <= 8'h00;
         latch_q      <= 8'h00;
         eoc_q        <= 1'b1;
         busy_q       <= 1'b0;
         dout_q       <= 8'h00;
         dout_en_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         start_prev_q <= start_prev_d;
         ale_q        <= ale_d;
         ale_prev_q   <= ale_prev_d;
         oe_q         <= oe_d;
         addr_q       <= addr_d;
         ch_q         <= ch_d;
         dly_q        <= dly_d;
         conv_q       <= conv_d;
         sample_q     <= sample_d;
         latch_q      <= latch_d;
         eoc_q        <= eoc_d;
         busy_q       <= busy_d;
         dout_q       <= dout_d;
         dout_en_q    <= dout_en_d;
      end
   end

   assign eoc     = eoc_q;
   assign busy    = busy_q;
   assign dout    = dout_q;
   assign dout_en = dout_en_q;

endmodule
